// File: rtl/approx_adder_err_sweeper_if.sv
// Operand, result and metric bundle between the error sweeper
// and the adder under evaluation / run control.
interface approx_adder_err_sweeper_if #(
    parameter int WIDTH = 8,
    parameter int SUM_W = 32
);
    logic               start;
    logic               abort;
    logic               mode;
    logic [2*WIDTH:0]   num_samples;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH:0]     dut_sum;
    logic               busy;
    logic               done;
    logic [2*WIDTH:0]   err_count;
    logic [WIDTH:0]     max_abs_err;
    logic [SUM_W-1:0]   sum_abs_err;

    // Environment side: run control and the adder result.
    modport master (
        output start,
        output abort,
        output mode,
        output num_samples,
        output dut_sum,
        input  op_a,
        input  op_b,
        input  busy,
        input  done,
        input  err_count,
        input  max_abs_err,
        input  sum_abs_err
    );

    // Sweeper side.
    modport slave (
        input  start,
        input  abort,
        input  mode,
        input  num_samples,
        input  dut_sum,
        output op_a,
        output op_b,
        output busy,
        output done,
        output err_count,
        output max_abs_err,
        output sum_abs_err
    );
endinterface

// File: rtl/approx_adder_err_sweeper.sv
// Sequences operand pairs into an approximate adder and
// accumulates error count, max |error| and sum |error|.
module approx_adder_err_sweeper #(
    parameter int                 WIDTH     = 8,
    parameter int                 SUM_W     = 32,
    parameter logic [2*WIDTH-1:0] LFSR_TAPS = 16'hB400,
    parameter logic [2*WIDTH-1:0] LFSR_SEED = 16'h0001
) (
    input logic                       clk,
    input logic                       rst_n,
    approx_adder_err_sweeper_if.slave bus
);
    localparam int GW = 2 * WIDTH;
    localparam int CW = 2 * WIDTH + 1;

    localparam logic [GW-1:0] ONE_G = {{(GW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};
    // A zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [GW-1:0] SEED  =
        (LFSR_SEED == '0) ? ONE_G : LFSR_SEED;
    // Exhaustive runs cover every {op_b, op_a} pair.
    localparam logic [CW-1:0] N_EXH = {1'b1, {GW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRN1,
        S_DRN2,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [GW-1:0]    gen_q;
    logic [GW-1:0]    lfsr_nxt;
    logic [CW-1:0]    idx_q;
    logic [CW-1:0]    nlim_q;
    logic             mode_q;

    logic             go;
    logic             empty;
    logic             last;
    logic             adv;

    logic             v1_q;
    logic [WIDTH:0]   ex1_q;
    logic [WIDTH:0]   du1_q;
    logic [WIDTH:0]   abs_d;
    logic [SUM_W:0]   sum_ext;
    logic [SUM_W-1:0] sum_nxt;

    logic [CW-1:0]    err_q;
    logic [WIDTH:0]   max_q;
    logic [SUM_W-1:0] sum_q;

    // Run-control decode: accepted start, empty random run, last vector.
    always_comb begin
        go    = bus.start &&
                ((state_q == S_IDLE) || (state_q == S_DONE));
        empty = bus.mode && (bus.num_samples == '0);
        last  = (idx_q == (nlim_q - ONE_C));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over every busy transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    state_d = empty ? S_DRN1 : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (last) begin
                    state_d = S_DRN1;
                end
            end
            S_DRN1: begin
                state_d = bus.abort ? S_IDLE : S_DRN2;
            end
            S_DRN2: begin
                state_d = bus.abort ? S_IDLE : S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        bus.busy = (state_q == S_RUN) ||
                   (state_q == S_DRN1) ||
                   (state_q == S_DRN2);
        bus.done = (state_q == S_DONE);
    end

    // One right-shift Galois step of the vector generator.
    always_comb begin
        lfsr_nxt = gen_q >> 1;
        if (gen_q[0]) begin
            lfsr_nxt = (gen_q >> 1) ^ LFSR_TAPS;
        end
        // Only step while staying in RUN so op_a/op_b hold afterwards.
        adv = (state_q == S_RUN) && (state_d == S_RUN);
    end

    // Vector generator, vector index and latched run parameters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_q  <= '0;
            idx_q  <= '0;
            nlim_q <= '0;
            mode_q <= 1'b0;
        end else if (go) begin
            if (!empty) begin
                gen_q <= bus.mode ? SEED : '0;
            end
            idx_q  <= '0;
            nlim_q <= bus.mode ? bus.num_samples : N_EXH;
            mode_q <= bus.mode;
        end else if (adv) begin
            gen_q <= mode_q ? lfsr_nxt : gen_q + ONE_G;
            idx_q <= idx_q + ONE_C;
        end
    end

    assign bus.op_a = gen_q[WIDTH-1:0];
    assign bus.op_b = gen_q[GW-1:WIDTH];

    // S1: capture exact sum and DUT result of the presented vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            ex1_q <= '0;
            du1_q <= '0;
        end else begin
            v1_q  <= (state_q == S_RUN) && !bus.abort;
            ex1_q <= {1'b0, gen_q[WIDTH-1:0]} +
                     {1'b0, gen_q[GW-1:WIDTH]};
            du1_q <= bus.dut_sum;
        end
    end

    // S2: unsigned error magnitude and saturating accumulation.
    always_comb begin
        if (ex1_q >= du1_q) begin
            abs_d = ex1_q - du1_q;
        end else begin
            abs_d = du1_q - ex1_q;
        end
        sum_ext = {1'b0, sum_q} +
                  {{(SUM_W-WIDTH){1'b0}}, abs_d};
        sum_nxt = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
    end

    // Metric registers; a new run clears them on the start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
            max_q <= '0;
            sum_q <= '0;
        end else if (go) begin
            err_q <= '0;
            max_q <= '0;
            sum_q <= '0;
        end else if (v1_q) begin
            if (abs_d != '0) begin
                err_q <= err_q + ONE_C;
            end
            if (abs_d > max_q) begin
                max_q <= abs_d;
            end
            sum_q <= sum_nxt;
        end
    end

    assign bus.err_count   = err_q;
    assign bus.max_abs_err = max_q;
    assign bus.sum_abs_err = sum_q;
endmodule
